// File: rtl/fft_frame_loader_pkg.sv
// Shared constants and the frame type for the 4-point FFT front end.
package fft_pkg;
  localparam int N_PTS     = 4;
  localparam int SAMPLE_W  = 2;
  localparam int DEF_CNT_W = 8;

  // Element [0] is the oldest sample of the frame.
  typedef logic [N_PTS-1:0][SAMPLE_W-1:0] frame_t;
endpackage

// File: rtl/fft_frame_loader_if.sv
// Sample-stream and frame handshakes of the frame loader; master is the loader side.
interface fft_frame_loader_if #(parameter int W = fft_pkg::SAMPLE_W);
  logic [W-1:0] s_data;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] i0;
  logic [W-1:0] i1;
  logic [W-1:0] i2;
  logic [W-1:0] i3;
  logic         f_valid;
  logic         f_ready;

  modport master (
    input  s_data, s_valid, f_ready,
    output s_ready, i0, i1, i2, i3, f_valid
  );

  modport slave (
    output s_data, s_valid, f_ready,
    input  s_ready, i0, i1, i2, i3, f_valid
  );
endinterface

// File: rtl/fft_frame_loader_bank.sv
// One ping-pong bank: four W-bit sample registers, written one address at a time.
module frame_bank
  import fft_pkg::*;
#(
  parameter int W = SAMPLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [1:0]   addr,
  input  logic [W-1:0] din,
  output logic [W-1:0] q0,
  output logic [W-1:0] q1,
  output logic [W-1:0] q2,
  output logic [W-1:0] q3
);

  logic [W-1:0] mem [N_PTS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_PTS; k++) mem[k] <= '0;
    end else if (we) begin
      mem[addr] <= din;
    end
  end

  assign q0 = mem[0];
  assign q1 = mem[1];
  assign q2 = mem[2];
  assign q3 = mem[3];

endmodule

// File: rtl/fft_frame_loader.sv
// Serial-to-frame loader: fills one bank while the FFT consumes the other.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int W     = SAMPLE_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  fft_frame_loader_if.master bus,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             partial
);

  logic [1:0] full;
  logic [1:0] full_nxt;
  logic       wr_sel;
  logic       rd_sel;
  logic [1:0] wr_cnt;
  logic       wr_fire;
  logic       rd_fire;
  logic       frame_done;

  logic [N_PTS-1:0][W-1:0] bank_q [2];

  assign bus.s_ready = ~full[wr_sel] & ~flush;
  assign bus.f_valid = full[rd_sel];
  assign wr_fire     = bus.s_valid & bus.s_ready;
  assign rd_fire     = bus.f_valid & bus.f_ready;
  assign frame_done  = wr_fire & (wr_cnt == 2'd3);
  assign partial     = (wr_cnt != 2'd0);

  // A write only targets a non-full bank and a pop only a full one, so both can land together.
  always_comb begin
    full_nxt = full;
    if (rd_fire)    full_nxt[rd_sel] = 1'b0;
    if (frame_done) full_nxt[wr_sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full      <= 2'b00;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      wr_cnt    <= 2'd0;
      frame_cnt <= '0;
    end else begin
      full <= full_nxt;
      if (flush) begin
        wr_cnt <= 2'd0;
      end else if (wr_fire) begin
        wr_cnt <= wr_cnt + 2'd1;
      end
      if (frame_done) wr_sel <= ~wr_sel;
      if (rd_fire) begin
        rd_sel    <= ~rd_sel;
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    frame_bank #(.W(W)) u_bank (
      .clk  (clk),
      .rst  (rst),
      .we   (wr_fire & (wr_sel == 1'(b))),
      .addr (wr_cnt),
      .din  (bus.s_data),
      .q0   (bank_q[b][0]),
      .q1   (bank_q[b][1]),
      .q2   (bank_q[b][2]),
      .q3   (bank_q[b][3])
    );
  end

  assign bus.i0 = bank_q[rd_sel][0];
  assign bus.i1 = bank_q[rd_sel][1];
  assign bus.i2 = bank_q[rd_sel][2];
  assign bus.i3 = bank_q[rd_sel][3];

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: queue-of-frames reference model plus directed literal checks.
module tb_fft_frame_loader;
  import fft_pkg::*;

  localparam int W = SAMPLE_W;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 flush = 1'b0;
  logic [DEF_CNT_W-1:0] frame_cnt;
  logic                 partial;

  int n_checks = 0;
  int n_pass   = 0;

  fft_frame_loader_if #(.W(W)) bus ();

  fft_frame_loader #(.W(W), .CNT_W(DEF_CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus.master),
    .frame_cnt (frame_cnt),
    .partial   (partial)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic frame_t dut_frame();
    frame_t f;
    f[0] = bus.i0;
    f[1] = bus.i1;
    f[2] = bus.i2;
    f[3] = bus.i3;
    return f;
  endfunction

  function automatic frame_t fr(input logic [W-1:0] a, b, c, d);
    frame_t f;
    f[0] = a;
    f[1] = b;
    f[2] = c;
    f[3] = d;
    return f;
  endfunction

  // Reference: completed frames wait in a FIFO of depth two; a partial frame collects in a list.
  frame_t       mdl_q[$];
  logic [W-1:0] mdl_fill[N_PTS];
  int           mdl_n   = 0;
  int           mdl_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      mdl_q.delete();
      mdl_n   = 0;
      mdl_cnt = 0;
    end else begin
      bit exp_sr;
      bit exp_fv;
      bit acc;
      bit pop;
      frame_t nf;
      exp_sr = (mdl_q.size() < 2) && !flush;
      exp_fv = (mdl_q.size() > 0);
      check_output("s_ready", bus.s_ready, exp_sr);
      check_output("f_valid", bus.f_valid, exp_fv);
      if (exp_fv) check_output("frame", dut_frame(), mdl_q[0]);
      check_output("frame_cnt", frame_cnt, mdl_cnt % (1 << DEF_CNT_W));
      check_output("partial", partial, mdl_n != 0);
      acc = bus.s_valid && exp_sr;
      pop = exp_fv && bus.f_ready;
      if (pop) begin
        void'(mdl_q.pop_front());
        mdl_cnt++;
      end
      if (flush) begin
        mdl_n = 0;
      end else if (acc) begin
        mdl_fill[mdl_n] = bus.s_data;
        mdl_n++;
        if (mdl_n == N_PTS) begin
          for (int k = 0; k < N_PTS; k++) nf[k] = mdl_fill[k];
          mdl_q.push_back(nf);
          mdl_n = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    bit acc;
    acc = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = bus.s_ready;
      @(posedge clk);
      #1;
    end
    bus.s_valid = 1'b0;
    if (!acc) check_output("send_timeout", acc, 1);
  endtask

  task automatic pop();
    bus.f_ready = 1'b1;
    tick();
    bus.f_ready = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc_n;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.f_ready = 1'b0;
    #12 rst = 1'b0;
    tick();
    check_output("init_s_ready", bus.s_ready, 1);
    check_output("init_f_valid", bus.f_valid, 0);

    // T1: reset with a frame pending and two samples in the fill bank
    send(2'd1); send(2'd2); send(2'd3); send(2'd1);
    send(2'd2); send(2'd3);
    check_output("t1_pre_f_valid", bus.f_valid, 1);
    check_output("t1_pre_partial", partial, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_output("t1_s_ready", bus.s_ready, 1);
    check_output("t1_f_valid", bus.f_valid, 0);
    check_output("t1_frame", dut_frame(), fr(2'd0, 2'd0, 2'd0, 2'd0));
    check_output("t1_partial", partial, 0);
    check_output("t1_frame_cnt", frame_cnt, 0);
    tick();
    rst = 1'b0;

    // T2: single frame 1,2,3,0
    send(2'd1); send(2'd2); send(2'd3);
    check_output("t2_not_yet_valid", bus.f_valid, 0);
    send(2'd0);
    check_output("t2_f_valid", bus.f_valid, 1);
    check_output("t2_frame", dut_frame(), fr(2'd1, 2'd2, 2'd3, 2'd0));
    pop();
    check_output("t2_popped", bus.f_valid, 0);
    check_output("t2_frame_cnt", frame_cnt, 1);

    // T3: both banks full, ninth sample held
    send(2'd0); send(2'd1); send(2'd2); send(2'd3);
    send(2'd3); send(2'd2); send(2'd1); send(2'd0);
    check_output("t3_stall", bus.s_ready, 0);
    bus.s_valid = 1'b1;
    bus.s_data  = 2'd2;
    tick();
    tick();
    check_output("t3_held", bus.s_ready, 0);
    check_output("t3_partial_held", partial, 0);
    check_output("t3_frame_a", dut_frame(), fr(2'd0, 2'd1, 2'd2, 2'd3));
    bus.f_ready = 1'b1;
    tick();
    bus.f_ready = 1'b0;
    check_output("t3_frame_b", dut_frame(), fr(2'd3, 2'd2, 2'd1, 2'd0));
    check_output("t3_ready_again", bus.s_ready, 1);
    tick();
    bus.s_valid = 1'b0;
    check_output("t3_ninth_taken", partial, 1);
    check_output("t3_frame_cnt", frame_cnt, 2);
    pop();

    // T4: frame B completes on the same edge that frame A is popped
    send(2'd1); send(2'd1); send(2'd0);
    check_output("t4_frame_a", dut_frame(), fr(2'd2, 2'd1, 2'd1, 2'd0));
    send(2'd3); send(2'd0); send(2'd2);
    bus.f_ready = 1'b1;
    send(2'd1);
    bus.f_ready = 1'b0;
    check_output("t4_f_valid", bus.f_valid, 1);
    check_output("t4_frame_b", dut_frame(), fr(2'd3, 2'd0, 2'd2, 2'd1));
    check_output("t4_frame_cnt", frame_cnt, 4);
    pop();

    // T5: flush drops a partial fill but leaves the pending frame alone
    send(2'd1); send(2'd3); send(2'd1); send(2'd3);
    send(2'd2); send(2'd1);
    flush       = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 2'd3;
    #1;
    check_output("t5_flush_reject", bus.s_ready, 0);
    @(posedge clk);
    #1;
    flush       = 1'b0;
    bus.s_valid = 1'b0;
    check_output("t5_partial", partial, 0);
    check_output("t5_pending", dut_frame(), fr(2'd1, 2'd3, 2'd1, 2'd3));
    send(2'd0); send(2'd1); send(2'd2); send(2'd3);
    pop();
    check_output("t5_new_frame", dut_frame(), fr(2'd0, 2'd1, 2'd2, 2'd3));
    pop();
    check_output("t5_empty", bus.f_valid, 0);
    check_output("t5_frame_cnt", frame_cnt, 7);

    // T6: random streaming, 256 frames wraps the counter to zero
    apply_reset();
    acc_n = 0;
    bus.s_data = W'($urandom_range(0, 3));
    for (int t = 0; t < 20000 && acc_n < 1024; t++) begin
      bus.s_valid = 1'b1;
      bus.f_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.s_ready) acc_n++;
      @(posedge clk);
      #1;
      if (bus.s_ready || flush) bus.s_data = W'($urandom_range(0, 3));
    end
    bus.s_valid = 1'b0;
    check_output("t6_accepted", acc_n, 1024);
    bus.f_ready = 1'b1;
    for (int t = 0; t < 10 && bus.f_valid; t++) tick();
    bus.f_ready = 1'b0;
    tick();
    check_output("t6_drained", bus.f_valid, 0);
    check_output("t6_frame_cnt_wrap", frame_cnt, 0);
    check_output("t6_partial", partial, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
